// File: rtl/cam_dvp_gen.sv
// cam_dvp_gen: synthetic DVP camera source (vsyn/href/RGB565 byte stream) with selectable test patterns.
// Optional macro CAM_GEN_CHECKSUM_EN adds frame_sum, the mod-2^16 pixel sum of the last complete frame.
`default_nettype none

module cam_dvp_gen #(
   parameter int H_ACTIVE = 1024,
   parameter int H_BLANK  = 256,
   parameter int V_SYNC   = 3,
   parameter int V_BACK   = 17,
   parameter int V_ACTIVE = 750,
   parameter int V_FRONT  = 10
) (
   input  logic        cmos_pclk,
   input  logic        rst_133,
   input  logic        enable,
   input  logic [1:0]  pattern_sel,
   output logic        cmos_vsyn,
   output logic        cmos_href,
   output logic [7:0]  cmos_data,
   output logic [15:0] frame_cnt,
`ifdef CAM_GEN_CHECKSUM_EN
   output logic [15:0] frame_sum,
`endif
   output logic        busy
);

   localparam int c_LINE_LEN = 2*H_ACTIVE + H_BLANK;
   localparam int c_CW       = $clog2(c_LINE_LEN);
   localparam int c_XW       = $clog2(H_ACTIVE);
   localparam logic [c_CW-1:0] c_COL_LAST = c_CW'(c_LINE_LEN - 1);
   localparam logic [c_CW-1:0] c_HREF_END = c_CW'(2*H_ACTIVE);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_VSYNC  = 3'd1,
      S_VBACK  = 3'd2,
      S_ACTIVE = 3'd3,
      S_VFRONT = 3'd4
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [c_CW-1:0]   r_col;
   logic [c_CW-1:0]   w_col_nxt;
   logic [15:0]       r_line;
   logic [15:0]       w_line_nxt;
   logic [1:0]        r_pat;
   logic              w_latch;
   logic              w_frame_end;
   logic              w_line_end;
   logic [15:0]       w_state_last;

   logic              r_vsyn;
   logic              r_href;
   logic [7:0]        r_data;
   logic [15:0]       r_frame_cnt;
   logic              r_busy;

   logic              w_href_nxt;
   logic [15:0]       w_x16;
   logic [2:0]        w_bar;
   logic [15:0]       w_pix;
   logic [15:0]       w_bar_pix;

   assign w_line_end = (r_col == c_COL_LAST);

   always_comb begin
      w_state_last = '0;
      case (r_state)
         S_VSYNC:  w_state_last = 16'(V_SYNC - 1);
         S_VBACK:  w_state_last = 16'(V_BACK - 1);
         S_ACTIVE: w_state_last = 16'(V_ACTIVE - 1);
         S_VFRONT: w_state_last = 16'(V_FRONT - 1);
         default:  w_state_last = '0;
      endcase
   end

   always_ff @(posedge cmos_pclk or negedge rst_133) begin
      if (!rst_133) begin
         r_state <= S_IDLE;
         r_col   <= '0;
         r_line  <= '0;
         r_pat   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_col   <= w_col_nxt;
         r_line  <= w_line_nxt;
         if (w_latch) begin
            r_pat <= pattern_sel;
         end
      end
   end

   // Counters only run outside IDLE; leaving IDLE always starts from col/line zero.
   always_comb begin
      w_state_nxt = r_state;
      w_col_nxt   = '0;
      w_line_nxt  = '0;
      w_latch     = 1'b0;
      w_frame_end = 1'b0;
      if (r_state == S_IDLE) begin
         if (enable) begin
            w_state_nxt = S_VSYNC;
            w_latch     = 1'b1;
         end
      end else begin
         w_col_nxt  = w_line_end ? '0 : r_col + c_CW'(1);
         w_line_nxt = r_line;
         if (w_line_end) begin
            if (r_line == w_state_last) begin
               w_line_nxt = '0;
               case (r_state)
                  S_VSYNC:  w_state_nxt = S_VBACK;
                  S_VBACK:  w_state_nxt = S_ACTIVE;
                  S_ACTIVE: w_state_nxt = S_VFRONT;
                  default: begin
                     w_frame_end = 1'b1;
                     if (enable) begin
                        w_state_nxt = S_VSYNC;
                        w_latch     = 1'b1;
                     end else begin
                        w_state_nxt = S_IDLE;
                     end
                  end
               endcase
            end else begin
               w_line_nxt = r_line + 16'd1;
            end
         end
      end
   end

   // Pixel generation from the current position; the output registers add the single cycle of latency.
   assign w_href_nxt = (r_state == S_ACTIVE) && (r_col < c_HREF_END);
   assign w_x16      = 16'(r_col[c_XW:1]);
   assign w_bar      = w_x16[c_XW-1 -: 3];

   always_comb begin
      w_bar_pix = 16'h0000;
      case (w_bar)
         3'd0:    w_bar_pix = 16'hFFFF;
         3'd1:    w_bar_pix = 16'hFFE0;
         3'd2:    w_bar_pix = 16'h07FF;
         3'd3:    w_bar_pix = 16'h07E0;
         3'd4:    w_bar_pix = 16'hF81F;
         3'd5:    w_bar_pix = 16'hF800;
         3'd6:    w_bar_pix = 16'h001F;
         default: w_bar_pix = 16'h0000;
      endcase
   end

   always_comb begin
      w_pix = 16'h0000;
      case (r_pat)
         2'd0:    w_pix = w_bar_pix;
         2'd1:    w_pix = w_x16;
         2'd2:    w_pix = (w_x16[3] ^ r_line[3]) ? 16'hFFFF : 16'h0000;
         default: w_pix = {r_frame_cnt[7:0], r_frame_cnt[7:0]};
      endcase
   end

   always_ff @(posedge cmos_pclk or negedge rst_133) begin
      if (!rst_133) begin
         r_vsyn      <= 1'b0;
         r_href      <= 1'b0;
         r_data      <= 8'h00;
         r_frame_cnt <= 16'h0000;
         r_busy      <= 1'b0;
      end else begin
         r_vsyn <= (r_state == S_VSYNC);
         r_href <= w_href_nxt;
         r_data <= w_href_nxt ? (r_col[0] ? w_pix[7:0] : w_pix[15:8]) : 8'h00;
         r_busy <= (w_state_nxt != S_IDLE);
         if (w_frame_end) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
         end
      end
   end

`ifdef CAM_GEN_CHECKSUM_EN
   logic [15:0] r_acc;
   logic [15:0] r_sum;

   // Each pixel is counted once, on its low-byte cycle.
   always_ff @(posedge cmos_pclk or negedge rst_133) begin
      if (!rst_133) begin
         r_acc <= 16'h0000;
         r_sum <= 16'h0000;
      end else if (w_frame_end) begin
         r_sum <= r_acc;
         r_acc <= 16'h0000;
      end else if (w_href_nxt && r_col[0]) begin
         r_acc <= r_acc + w_pix;
      end
   end

   assign frame_sum = r_sum;
`endif

   assign cmos_vsyn = r_vsyn;
   assign cmos_href = r_href;
   assign cmos_data = r_data;
   assign frame_cnt = r_frame_cnt;
   assign busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_cam_dvp_gen.sv
// tb_cam_dvp_gen: frame-level reference model plus constant byte tables for cam_dvp_gen.
`default_nettype none

module tb_cam_dvp_gen;

   localparam int HA = 16;
   localparam int HB = 4;
   localparam int VS = 2;
   localparam int VB = 1;
   localparam int VA = 4;
   localparam int VF = 1;
   localparam int L  = 2*HA + HB;
   localparam int F  = (VS + VB + VA + VF) * L;
   localparam int CAPN = VA * 2 * HA;

   logic        cmos_pclk = 1'b0;
   logic        rst_133;
   logic        enable;
   logic [1:0]  pattern_sel;
   logic        cmos_vsyn;
   logic        cmos_href;
   logic [7:0]  cmos_data;
   logic [15:0] frame_cnt;
   logic        busy;
`ifdef CAM_GEN_CHECKSUM_EN
   logic [15:0] frame_sum;
`endif

   int checks = 0;
   int errors = 0;
   logic [7:0]  cap [4][CAPN];
   logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                             16'hF81F, 16'hF800, 16'h001F, 16'h0000};

   typedef struct {
      int         pat;
      int         line;
      int         col;
      logic [7:0] exp;
   } vec_t;
   vec_t tbl[$];

   cam_dvp_gen #(
      .H_ACTIVE (HA), .H_BLANK (HB), .V_SYNC (VS),
      .V_BACK (VB), .V_ACTIVE (VA), .V_FRONT (VF)
   ) dut (
      .cmos_pclk   (cmos_pclk),
      .rst_133     (rst_133),
      .enable      (enable),
      .pattern_sel (pattern_sel),
      .cmos_vsyn   (cmos_vsyn),
      .cmos_href   (cmos_href),
      .cmos_data   (cmos_data),
      .frame_cnt   (frame_cnt),
`ifdef CAM_GEN_CHECKSUM_EN
      .frame_sum   (frame_sum),
`endif
      .busy        (busy)
   );

   always #5 cmos_pclk = ~cmos_pclk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1);
   end

   function automatic logic [15:0] ref_pix(int pat, int x, int y, logic [15:0] fc);
      case (pat)
         0:       return bars[(x * 8) / HA];
         1:       return 16'(x);
         2:       return (((x / 8) % 2) != ((y / 8) % 2)) ? 16'hFFFF : 16'h0000;
         default: return {fc[7:0], fc[7:0]};
      endcase
   endfunction

   // Expected {vsyn, href, data} k cycles after vsyn rises.
   function automatic logic [9:0] ref_out(int k, int pat, logic [15:0] fc);
      int lp = k / L;
      int c  = k % L;
      logic vs  = (lp < VS);
      logic act = (lp >= VS + VB) && (lp < VS + VB + VA) && (c < 2*HA);
      logic [15:0] p = act ? ref_pix(pat, c / 2, lp - VS - VB, fc) : 16'h0000;
      logic [7:0] d = act ? ((c % 2 == 0) ? p[15:8] : p[7:0]) : 8'h00;
      return {vs, act, d};
   endfunction

   function automatic logic [15:0] ref_sum(int pat, logic [15:0] fc);
      int s = 0;
      for (int y = 0; y < VA; y++)
         for (int x = 0; x < HA; x++)
            s += int'(ref_pix(pat, x, y, fc));
      return 16'(s);
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Enters with enable sampled at the next edge; leaves at the sample where vsyn should first be high.
   task automatic start_run(input int pat);
      pattern_sel = 2'(pat);
      enable = 1'b1;
      @(negedge cmos_pclk);
      check("start_vsyn_low", {31'd0, cmos_vsyn}, 32'd0);
      check("start_busy", {31'd0, busy}, 32'd1);
      @(negedge cmos_pclk);
   endtask

   // Compares one whole frame cycle by cycle; inputs are disturbed mid-frame to show they are ignored.
   task automatic check_frame(input int pat, input logic [15:0] fc, input int fno,
                              input int next_pat, input bit next_en);
      int bad = 0;
      int first_k = -1;
      int n = 0;
      logic [9:0] exp_o, got_o, got_f, exp_f;
      logic [15:0] fc_exp;
      for (int k = 0; k < F; k++) begin
         exp_o  = ref_out(k, pat, fc);
         got_o  = {cmos_vsyn, cmos_href, cmos_data};
         fc_exp = (k == F - 1) ? 16'(fc + 16'd1) : fc;
         if (got_o !== exp_o || frame_cnt !== fc_exp || (k < F - 1 && busy !== 1'b1)) begin
            bad++;
            if (first_k < 0) begin
               first_k = k;
               got_f = got_o;
               exp_f = exp_o;
            end
         end
         if (cmos_href === 1'b1 && fno >= 0 && n < CAPN) begin
            cap[fno][n] = cmos_data;
            n++;
         end
         if (k == F / 3) pattern_sel = 2'($urandom_range(0, 3));
         if (k == (2 * F) / 3) begin
            pattern_sel = 2'(next_pat);
            enable = next_en;
         end
         @(negedge cmos_pclk);
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL frame pat=%0d fc=%0d: %0d bad cycles, first k=%0d got {vsyn,href,data}=%h expected %h",
                  pat, fc, bad, first_k, got_f, exp_f);
      end
`ifdef CAM_GEN_CHECKSUM_EN
      check("frame_sum", {16'd0, frame_sum}, {16'd0, ref_sum(pat, fc)});
`endif
   endtask

   task automatic check_idle(input logic [15:0] fc);
      int bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (cmos_vsyn !== 1'b0 || cmos_href !== 1'b0 || cmos_data !== 8'h00 ||
             busy !== 1'b0 || frame_cnt !== fc) bad++;
         @(negedge cmos_pclk);
      end
      check("idle_quiet_cycles_bad", bad, 0);
   endtask

   initial begin
      int cur;
      int nxt;
      bit en;
      logic [15:0] fc;

      tbl.push_back('{0, 0, 0, 8'hFF});  tbl.push_back('{0, 0, 5, 8'hE0});
      tbl.push_back('{0, 0, 8, 8'h07});  tbl.push_back('{0, 0, 9, 8'hFF});
      tbl.push_back('{0, 0, 13, 8'hE0}); tbl.push_back('{0, 0, 16, 8'hF8});
      tbl.push_back('{0, 0, 17, 8'h1F}); tbl.push_back('{0, 0, 21, 8'h00});
      tbl.push_back('{0, 0, 25, 8'h1F}); tbl.push_back('{0, 0, 31, 8'h00});
      tbl.push_back('{0, 2, 4, 8'hFF});
      tbl.push_back('{1, 0, 1, 8'h00});  tbl.push_back('{1, 0, 3, 8'h01});
      tbl.push_back('{1, 0, 30, 8'h00}); tbl.push_back('{1, 0, 31, 8'h0F});
      tbl.push_back('{1, 3, 31, 8'h0F});
      tbl.push_back('{2, 0, 0, 8'h00});  tbl.push_back('{2, 0, 16, 8'hFF});
      tbl.push_back('{2, 1, 15, 8'h00}); tbl.push_back('{2, 3, 31, 8'hFF});
      tbl.push_back('{3, 0, 0, 8'h03});  tbl.push_back('{3, 3, 31, 8'h03});

      rst_133 = 1'b0;
      enable = 1'b0;
      pattern_sel = 2'd0;
      repeat (3) @(negedge cmos_pclk);
      check("reset_outputs", {cmos_vsyn, cmos_href, cmos_data, frame_cnt, busy}, 32'd0);
      rst_133 = 1'b1;
      repeat (3) @(negedge cmos_pclk);
      check_idle(16'd0);

      // Patterns 0..3 back to back; frame_cnt runs 0..3 so the fill frame sends 03.
      fc = 16'd0;
      start_run(0);
      for (int p = 0; p < 4; p++) begin
         check_frame(p, fc, p, (p + 1) % 4, 1'b1);
         fc = 16'(fc + 16'd1);
      end
      for (int i = 0; i < tbl.size(); i++)
         check($sformatf("table_p%0d_l%0d_c%0d", tbl[i].pat, tbl[i].line, tbl[i].col),
               {24'd0, cap[tbl[i].pat][tbl[i].line * 2 * HA + tbl[i].col]}, {24'd0, tbl[i].exp});

      // Random sequence of patterns with occasional stops at frame boundaries.
      cur = 0;
      for (int f = 0; f < 10; f++) begin
         nxt = $urandom_range(0, 3);
         en = (f == 9) ? 1'b0 : ($urandom_range(0, 3) != 0);
         check_frame(cur, fc, -1, nxt, en);
         fc = 16'(fc + 16'd1);
         if (!en) begin
            check_idle(fc);
            if (f != 9) start_run(nxt);
         end
         cur = nxt;
      end

      // Asynchronous reset in the middle of an active line.
      start_run(1);
      repeat ((VS + VB) * L + 10) @(negedge cmos_pclk);
      check("pre_reset_href", {31'd0, cmos_href}, 32'd1);
      #1 rst_133 = 1'b0;
      #1 check("async_reset_outputs", {cmos_vsyn, cmos_href, cmos_data, frame_cnt, busy}, 32'd0);
      repeat (2) @(negedge cmos_pclk);
      check("held_reset_outputs", {cmos_vsyn, cmos_href, cmos_data, frame_cnt, busy}, 32'd0);
      rst_133 = 1'b1;
      start_run(2);
      check_frame(2, 16'd0, -1, 0, 1'b0);
      check_idle(16'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
